// File: rtl/register_file.sv
// 8 x 16-bit register file: one synchronous write port, two combinational read ports.
// All state updates on the falling edge of clk_n; no hard-wired zero register.
module register_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk_n,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Waddr,
  input  logic [DATA_W-1:0] WData,
  input  logic              WE,
  input  logic [ADDR_W-1:0] Aaddr,
  input  logic [ADDR_W-1:0] Baddr,
  output logic [DATA_W-1:0] AData,
  output logic [DATA_W-1:0] BData
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0]             w_wr_en;
  logic [DEPTH-1:0][DATA_W-1:0] w_regs;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic [DATA_W-1:0] r_q;

      // WE gates the decode so an unknown Waddr cannot disturb state while idle.
      assign w_wr_en[gi] = WE && (Waddr == ADDR_W'(gi));

      always_ff @(negedge clk_n) begin
        if (rst) begin
          r_q <= '0;
        end else if (w_wr_en[gi]) begin
          r_q <= WData;
        end
      end

      assign w_regs[gi] = r_q;
    end
  endgenerate

  // Read ports come straight from storage: no bypass of WData.
  assign AData = w_regs[Aaddr];
  assign BData = w_regs[Baddr];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed test-plan steps plus random traffic,
// compared against an array model on every half cycle once reset has been seen.
module tb_register_file;

  logic        clk_n;
  logic        rst;
  logic [2:0]  Waddr;
  logic [15:0] WData;
  logic        WE;
  logic [2:0]  Aaddr;
  logic [2:0]  Baddr;
  logic [15:0] AData;
  logic [15:0] BData;

  int tests;
  int fails;

  logic [15:0] m_regs [8];
  logic        m_valid;

  logic [15:0] fill_vals [8];

  register_file #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk_n (clk_n),
    .rst   (rst),
    .Waddr (Waddr),
    .WData (WData),
    .WE    (WE),
    .Aaddr (Aaddr),
    .Baddr (Baddr),
    .AData (AData),
    .BData (BData)
  );

  initial begin
    clk_n = 1'b1;
    forever #10 clk_n = ~clk_n;
  end

  // Reference model: storage changes only at the falling edge of clk_n.
  initial m_valid = 1'b0;
  always @(negedge clk_n) begin
    if (rst === 1'b1) begin
      for (int i = 0; i < 8; i++) m_regs[i] <= 16'h0000;
      m_valid <= 1'b1;
    end else if (WE === 1'b1) begin
      m_regs[Waddr] <= WData;
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Continuous comparison: mid-cycle after inputs settle, and just after each active edge.
  always @(posedge clk_n) begin
    #2;
    if (m_valid) begin
      chk("model_A_hi", AData, m_regs[Aaddr]);
      chk("model_B_hi", BData, m_regs[Baddr]);
    end
  end

  always @(negedge clk_n) begin
    #2;
    if (m_valid) begin
      chk("model_A_lo", AData, m_regs[Aaddr]);
      chk("model_B_lo", BData, m_regs[Baddr]);
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    fill_vals[0] = 16'h1111; fill_vals[1] = 16'h2222;
    fill_vals[2] = 16'h4444; fill_vals[3] = 16'h8888;
    fill_vals[4] = 16'h9999; fill_vals[5] = 16'haaaa;
    fill_vals[6] = 16'hcccc; fill_vals[7] = 16'hdddd;
    rst = 1'b0; WE = 1'b0; Waddr = '0; WData = '0; Aaddr = '0; Baddr = '0;

    // Reset with a competing write.
    @(posedge clk_n);
    rst = 1'b1; WE = 1'b1; Waddr = 3'd0; WData = 16'h1234;
    @(posedge clk_n);
    rst = 1'b0; WE = 1'b0;
    for (int a = 0; a < 8; a++) begin
      Aaddr = 3'(a); Baddr = 3'(7 - a);
      #1;
      chk("reset_A", AData, 16'h0000);
      chk("reset_B", BData, 16'h0000);
    end

    // Sequential fill with staggered reads one cycle behind the writes.
    for (int i = 0; i <= 8; i++) begin
      @(posedge clk_n);
      if (i < 8) begin
        WE = 1'b1; Waddr = 3'(i); WData = fill_vals[i];
      end else begin
        WE = 1'b0;
      end
      if (i > 0) begin
        if (((i - 1) % 2) == 0) begin
          Aaddr = 3'(i - 1); #1;
          chk("fill_A", AData, fill_vals[i-1]);
        end else begin
          Baddr = 3'(i - 1); #1;
          chk("fill_B", BData, fill_vals[i-1]);
        end
      end
    end

    // Write disable.
    @(posedge clk_n);
    WE = 1'b0; Waddr = 3'd0; WData = 16'h0000;
    @(posedge clk_n);
    Aaddr = 3'd0; #1;
    chk("we_off", AData, 16'h1111);

    // Overwrite addresses 0 and 1.
    @(posedge clk_n);
    WE = 1'b1; Waddr = 3'd0; WData = 16'heeee;
    @(posedge clk_n);
    Waddr = 3'd1; WData = 16'hffff;
    @(posedge clk_n);
    WE = 1'b0; Aaddr = 3'd0; Baddr = 3'd1; #1;
    chk("ovw_A", AData, 16'heeee);
    chk("ovw_B", BData, 16'hffff);
    for (int a = 2; a < 8; a++) begin
      Aaddr = 3'(a); #1;
      chk("ovw_other", AData, fill_vals[a]);
    end

    // Read-during-write: old value before the edge, new after; rising edge is inert.
    @(posedge clk_n);
    Aaddr = 3'd3; Waddr = 3'd3; WE = 1'b1; WData = 16'h5a5a; #1;
    chk("rdw_before", AData, 16'h8888);
    @(negedge clk_n); #1;
    chk("rdw_after", AData, 16'h5a5a);
    WData = 16'h1357;
    @(posedge clk_n); #1;
    chk("rise_inert", AData, 16'h5a5a);
    WE = 1'b0;
    @(negedge clk_n); #1;
    chk("rdw_hold", AData, 16'h5a5a);

    // Same-address dual read.
    @(posedge clk_n);
    Aaddr = 3'd5; Baddr = 3'd5; #1;
    chk("same_addr_A", AData, 16'haaaa);
    chk("same_addr_AB", BData, AData);

    // Reset between edges must not clear anything.
    rst = 1'b1; #3; rst = 1'b0; #1;
    chk("no_async_rst", AData, 16'haaaa);

    // Reset priority over a write on the same edge.
    @(posedge clk_n);
    rst = 1'b1; WE = 1'b1; Waddr = 3'd5; WData = 16'hbeef;
    @(negedge clk_n); #1;
    chk("rst_prio_A", AData, 16'h0000);
    chk("rst_prio_B", BData, 16'h0000);
    rst = 1'b0; WE = 1'b0;

    // Random traffic; the compare processes check every half cycle.
    for (int n = 0; n < 400; n++) begin
      @(posedge clk_n);
      rst   = ($urandom_range(0, 39) == 0);
      WE    = $urandom_range(0, 1);
      Waddr = 3'($urandom_range(0, 7));
      WData = 16'($urandom);
      Aaddr = 3'($urandom_range(0, 7));
      Baddr = ($urandom_range(0, 3) == 0) ? Waddr : 3'($urandom_range(0, 7));
    end
    @(posedge clk_n);
    rst = 1'b0; WE = 1'b0;
    @(posedge clk_n); #5;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
